// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word access to a word-wide memory.
// Sub-word stores are read-modify-write; loads are lane-extracted and extended.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic        err_q, err_d;

  logic        illegal;
  logic        misalign;
  logic        bad;
  logic        is_sw;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ext;
  logic [31:0] merged;

  // Reject unknown width codes, unsigned stores and misaligned H/W accesses
  always_comb begin
    illegal  = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11)
            || (req_we && req_funct3[2]);
    misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0])
            || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    bad      = illegal || misalign;
    is_sw    = req_we && (req_funct3 == 3'b010);
  end

  // Next state and request capture
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = bad;
          word_d  = '0;
          if (bad)        state_d = RESP;
          else if (is_sw) state_d = WRITE;
          else            state_d = READ;
        end
      end
      READ: begin
        word_d  = mem_rd;
        state_d = we_q ? WRITE : RESP;
      end
      WRITE: state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and captured request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end

  // Lane merge for stores and lane extension for loads
  always_comb begin
    lane_b = word_q[{addr_q[1:0], 3'b000} +: 8];
    lane_h = word_q[{addr_q[1], 4'b0000} +: 16];
    merged = word_q;
    unique case (f3_q[1:0])
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
    unique case (f3_q)
      3'b000:  ext = {{24{lane_b[7]}}, lane_b};
      3'b001:  ext = {{16{lane_h[15]}}, lane_h};
      3'b100:  ext = {24'd0, lane_b};
      3'b101:  ext = {16'd0, lane_h};
      default: ext = word_q;
    endcase
  end

  // Outputs; reset suppresses any write or response in flight
  always_comb begin
    req_ready = (state_q == IDLE);
    mem_a     = '0;
    if ((state_q == READ) || (state_q == WRITE))
      mem_a = {addr_q[31:2], 2'b00};
    mem_we    = (state_q == WRITE) && !rst;
    mem_wd    = mem_we ? merged : '0;
    rsp_valid = (state_q == RESP) && !rst;
    rsp_err   = rsp_valid && err_q;
    rsp_rdata = (rsp_valid && !err_q && !we_q) ? ext : '0;
  end

endmodule
